sync_deframer: RTL and testbench

Parametrised serial-to-parallel deframer that supersedes the fixed 64-bit shift buffer. It shifts in one bit per enabled clock and compares the window against a masked sync pattern, with a configurable bit-error tolerance. On a match it captures the whole frame into a holding register and pulses a valid strobe. It then locks out re-detection for one frame length, so frames never overlap, and keeps a saturating packet counter. It sits between the bit-slicer/demodulator output and the packet parser.

---
 rtl/sync_deframer_pkg.sv | 13 +
 rtl/popcount_masked.sv | 20 ++
 rtl/sync_deframer.sv | 107 ++++++++++
 tb/tb_sync_deframer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_deframer_pkg.sv
// Shared types and default sync word for the serial deframer.
// The defaults describe the 64-bit frame; wider or narrower frames size-cast them.
package sync_deframer_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCK   = 1'b1
  } state_t;

  localparam logic [63:0] DEF_SYNC_MASK = 64'h7C00_001F_0000_01FF;
  localparam logic [63:0] DEF_SYNC_PAT  = 64'h7C00_001F_0000_01FF;

endpackage

// File: rtl/popcount_masked.sv
// Counts the bit positions where a and b differ, restricted to positions set in mask.
// Purely combinational so it can be shared with other header checks.
module popcount_masked #(
  parameter int W  = 64,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  mask,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'((a[i] ^ b[i]) & mask[i]);
    end
  end

endmodule

// File: rtl/sync_deframer.sv
// Serial-to-parallel deframer: sliding window sync search with error tolerance,
// frame capture, post-detection lockout and a saturating packet counter.
module sync_deframer
  import sync_deframer_pkg::*;
#(
  parameter int               PKT_W     = 64,
  parameter logic [PKT_W-1:0] SYNC_MASK = PKT_W'(DEF_SYNC_MASK),
  parameter logic [PKT_W-1:0] SYNC_PAT  = PKT_W'(DEF_SYNC_PAT),
  parameter int               MAX_ERR   = 0,
  parameter int               CNT_W     = 16,
  localparam int              ERR_W     = $clog2(PKT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             clr_cnt,
  output logic [PKT_W-1:0] pkt_data,
  output logic             pkt_valid,
  output logic [ERR_W-1:0] err_bits,
  output logic             locked,
  output logic [CNT_W-1:0] pkt_cnt
);

  state_t           state, state_nxt;
  logic [PKT_W-1:0] sr;
  logic [PKT_W-1:0] nxt;
  logic [ERR_W-1:0] mism;
  logic [ERR_W-1:0] fill_cnt;
  logic [ERR_W-1:0] lock_cnt;
  logic             fill_ok;
  logic             match;
  logic             accept;

  assign nxt = {sr[PKT_W-2:0], din};

  popcount_masked #(
    .W  (PKT_W),
    .CW (ERR_W)
  ) u_popcount (
    .a     (nxt),
    .b     (SYNC_PAT),
    .mask  (SYNC_MASK),
    .count (mism)
  );

  // The current bit completes the first full window once fill_cnt is PKT_W-1.
  assign fill_ok = (fill_cnt >= ERR_W'(PKT_W - 1));
  assign match   = (mism <= ERR_W'(MAX_ERR));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SEARCH;
    else      state <= state_nxt;
  end

  // lock_cnt holds the number of locked bits still to come, so the first
  // evaluated window after a frame is exactly disjoint from it.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      SEARCH: begin
        if (en && fill_ok && match) begin
          accept    = 1'b1;
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        if (en && (lock_cnt <= ERR_W'(1))) state_nxt = SEARCH;
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    locked = (state == LOCK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr        <= '0;
      fill_cnt  <= '0;
      lock_cnt  <= '0;
      pkt_data  <= '0;
      pkt_valid <= 1'b0;
      err_bits  <= '0;
      pkt_cnt   <= '0;
    end else begin
      pkt_valid <= accept;
      if (en) begin
        sr <= nxt;
        if (fill_cnt != ERR_W'(PKT_W)) fill_cnt <= fill_cnt + ERR_W'(1);
      end
      if (accept) begin
        pkt_data <= nxt;
        err_bits <= mism;
        lock_cnt <= ERR_W'(PKT_W - 1);
      end else if (en && (state == LOCK) && (lock_cnt != '0)) begin
        lock_cnt <= lock_cnt - ERR_W'(1);
      end
      // A clear in the same cycle as an acceptance still counts that frame.
      if (clr_cnt)                       pkt_cnt <= accept ? CNT_W'(1) : '0;
      else if (accept && pkt_cnt != '1) pkt_cnt <= pkt_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sync_deframer.sv
// Bench for sync_deframer: three instances (default, MAX_ERR=1, CNT_W=2) share one
// bit stream and are compared against a window/popcount reference model.
module tb_sync_deframer;

  localparam logic [63:0] FRAME = 64'h7C00_001F_0000_01FF;
  localparam logic [63:0] MASK  = 64'h7C00_001F_0000_01FF;
  localparam logic [63:0] PAT   = 64'h7C00_001F_0000_01FF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0, din = 1'b0, clr_cnt = 1'b0;

  logic [63:0] pd0, pd1, pd2;
  logic [6:0]  eb0, eb1, eb2;
  logic        v0, v1, v2, lk0, lk1, lk2;
  logic [15:0] pc0, pc1;
  logic [1:0]  pc2;

  logic [63:0] pd[3];
  logic [6:0]  eb[3];
  logic        v[3], lk[3];
  logic [15:0] pc[3];

  always #5 clk = ~clk;

  sync_deframer dut0 (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
    .pkt_data(pd0), .pkt_valid(v0), .err_bits(eb0), .locked(lk0), .pkt_cnt(pc0)
  );
  sync_deframer #(.MAX_ERR(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
    .pkt_data(pd1), .pkt_valid(v1), .err_bits(eb1), .locked(lk1), .pkt_cnt(pc1)
  );
  sync_deframer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
    .pkt_data(pd2), .pkt_valid(v2), .err_bits(eb2), .locked(lk2), .pkt_cnt(pc2)
  );

  always_comb begin
    pd[0] = pd0; pd[1] = pd1; pd[2] = pd2;
    eb[0] = eb0; eb[1] = eb1; eb[2] = eb2;
    v[0]  = v0;  v[1]  = v1;  v[2]  = v2;
    lk[0] = lk0; lk[1] = lk1; lk[2] = lk2;
    pc[0] = pc0; pc[1] = pc1; pc[2] = {14'b0, pc2};
  end

  // Reference model: bit history window, bits since reset, last acceptance index.
  int          max_err[3] = '{0, 1, 0};
  int          cnt_max[3] = '{65535, 65535, 3};
  logic [63:0] m_win;
  int          m_nb;
  int          m_last[3];
  logic [63:0] e_data[3];
  int          e_err[3], e_cnt[3];
  int          e_lock_sum[3], o_lock_sum[3];
  int          exp_vq[3][$];
  int          obs_vq[3][$];

  int tests_run = 0;
  int tests_failed = 0;

  task automatic model_reset();
    m_win = '0;
    m_nb  = 0;
    for (int i = 0; i < 3; i++) begin
      m_last[i] = -100000;
      e_data[i] = '0;
      e_err[i]  = 0;
      e_cnt[i]  = 0;
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 3; i++) begin
      exp_vq[i].delete();
      obs_vq[i].delete();
      e_lock_sum[i] = 0;
      o_lock_sum[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; din = 1'b0; clr_cnt = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One clock: drive, update the model at the edge, sample the DUTs mid-cycle.
  task automatic step(input bit e, input bit d, input bit c);
    int mm;
    bit acc;
    en = e; din = d; clr_cnt = c;
    @(posedge clk);
    if (e) begin
      m_win = {m_win[62:0], d};
      m_nb++;
    end
    mm = $countones((m_win ^ PAT) & MASK);
    for (int i = 0; i < 3; i++) begin
      acc = e && (m_nb >= 64) && (m_nb - m_last[i] >= 64) && (mm <= max_err[i]);
      if (acc) begin
        m_last[i] = m_nb;
        e_data[i] = m_win;
        e_err[i]  = mm;
        exp_vq[i].push_back(m_nb);
      end
      if (c) e_cnt[i] = acc ? 1 : 0;
      else if (acc && e_cnt[i] < cnt_max[i]) e_cnt[i]++;
      if (m_last[i] >= 0 && (m_nb - m_last[i]) < 63) e_lock_sum[i]++;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (v[i]) obs_vq[i].push_back(m_nb);
      if (lk[i]) o_lock_sum[i]++;
    end
  endtask

  task automatic send_word(input logic [63:0] w, input int n, input bit toggle, input bit clr_last);
    for (int k = n - 1; k >= 0; k--) begin
      step(1'b1, w[k], clr_last && (k == 0));
      if (toggle) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  function automatic bit q_match(input int i);
    if (obs_vq[i].size() != exp_vq[i].size()) return 1'b0;
    for (int k = 0; k < obs_vq[i].size(); k++)
      if (obs_vq[i][k] != exp_vq[i][k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int first_of(input int i, input bit obs);
    if (obs) return (obs_vq[i].size() > 0) ? obs_vq[i][0] : -1;
    return (exp_vq[i].size() > 0) ? exp_vq[i][0] : -1;
  endfunction

  task automatic test_reset();
    clear_obs();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tests_run += 5;
      if (pd[i] !== 64'd0) begin tests_failed++; $display("FAIL reset pkt_data[%0d]: got %h, expected 0", i, pd[i]); end
      if (v[i] !== 1'b0)   begin tests_failed++; $display("FAIL reset pkt_valid[%0d]: got %b, expected 0", i, v[i]); end
      if (eb[i] !== 7'd0)  begin tests_failed++; $display("FAIL reset err_bits[%0d]: got %0d, expected 0", i, eb[i]); end
      if (lk[i] !== 1'b0)  begin tests_failed++; $display("FAIL reset locked[%0d]: got %b, expected 0", i, lk[i]); end
      if (pc[i] !== 16'd0) begin tests_failed++; $display("FAIL reset pkt_cnt[%0d]: got %0d, expected 0", i, pc[i]); end
    end
    do_reset();
  endtask

  task automatic test_frame();
    do_reset();
    clear_obs();
    send_word(64'hAC, 8, 1'b0, 1'b0);
    send_word(FRAME, 64, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    tests_run += 4;
    if (obs_vq[0].size() != 1 || first_of(0, 1) != 72) begin
      tests_failed++; $display("FAIL frame pulse: got %0d pulses first at bit %0d, expected 1 at bit 72", obs_vq[0].size(), first_of(0, 1));
    end
    if (pd[0] !== FRAME)  begin tests_failed++; $display("FAIL frame pkt_data: got %h, expected %h", pd[0], FRAME); end
    if (eb[0] !== 7'd0)   begin tests_failed++; $display("FAIL frame err_bits: got %0d, expected 0", eb[0]); end
    if (pc[0] !== 16'd1)  begin tests_failed++; $display("FAIL frame pkt_cnt: got %0d, expected 1", pc[0]); end
    for (int i = 0; i < 3; i++) begin
      tests_run += 2;
      if (!q_match(i)) begin tests_failed++; $display("FAIL frame model pulses[%0d]: got %0d first %0d, expected %0d first %0d", i, obs_vq[i].size(), first_of(i, 1), exp_vq[i].size(), first_of(i, 0)); end
      if (pd[i] !== e_data[i]) begin tests_failed++; $display("FAIL frame model pkt_data[%0d]: got %h, expected %h", i, pd[i], e_data[i]); end
    end
  endtask

  task automatic test_bit_error();
    logic [63:0] bad;
    bad = FRAME ^ (64'd1 << 60);
    do_reset();
    clear_obs();
    send_word(64'hAC, 8, 1'b0, 1'b0);
    send_word(bad, 64, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    tests_run += 5;
    if (obs_vq[0].size() != 0) begin tests_failed++; $display("FAIL biterr strict pulses: got %0d, expected 0", obs_vq[0].size()); end
    if (pc[0] !== 16'd0)       begin tests_failed++; $display("FAIL biterr strict pkt_cnt: got %0d, expected 0", pc[0]); end
    if (obs_vq[1].size() != 1 || first_of(1, 1) != 72) begin
      tests_failed++; $display("FAIL biterr tolerant pulse: got %0d pulses first at %0d, expected 1 at 72", obs_vq[1].size(), first_of(1, 1));
    end
    if (eb[1] !== 7'd1) begin tests_failed++; $display("FAIL biterr tolerant err_bits: got %0d, expected 1", eb[1]); end
    if (pd[1] !== bad)  begin tests_failed++; $display("FAIL biterr tolerant pkt_data: got %h, expected %h", pd[1], bad); end
    for (int i = 0; i < 3; i++) begin
      tests_run += 2;
      if (!q_match(i)) begin tests_failed++; $display("FAIL biterr model pulses[%0d]: got %0d, expected %0d", i, obs_vq[i].size(), exp_vq[i].size()); end
      if (eb[i] !== 7'(e_err[i])) begin tests_failed++; $display("FAIL biterr model err_bits[%0d]: got %0d, expected %0d", i, eb[i], e_err[i]); end
    end
  endtask

  task automatic test_all_ones();
    do_reset();
    clear_obs();
    send_word('1, 64, 1'b0, 1'b0);
    send_word('1, 64, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    tests_run += 2;
    if (obs_vq[0].size() != 2 || obs_vq[0][0] != 64 || obs_vq[0][1] != 128) begin
      tests_failed++; $display("FAIL ones pulses: got %0d pulses first at %0d, expected bits 64 and 128", obs_vq[0].size(), first_of(0, 1));
    end
    if (pc[0] !== 16'd2) begin tests_failed++; $display("FAIL ones pkt_cnt: got %0d, expected 2", pc[0]); end
    for (int i = 0; i < 3; i++) begin
      tests_run += 3;
      if (!q_match(i)) begin tests_failed++; $display("FAIL ones model pulses[%0d]: got %0d, expected %0d", i, obs_vq[i].size(), exp_vq[i].size()); end
      if (o_lock_sum[i] != e_lock_sum[i]) begin tests_failed++; $display("FAIL ones locked cycles[%0d]: got %0d, expected %0d", i, o_lock_sum[i], e_lock_sum[i]); end
      if (pc[i] !== 16'(e_cnt[i])) begin tests_failed++; $display("FAIL ones model pkt_cnt[%0d]: got %0d, expected %0d", i, pc[i], e_cnt[i]); end
    end
  endtask

  task automatic test_en_toggle();
    do_reset();
    clear_obs();
    send_word(64'hAC, 8, 1'b1, 1'b0);
    send_word(FRAME, 64, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    tests_run += 3;
    if (pd[0] !== FRAME)       begin tests_failed++; $display("FAIL toggle pkt_data: got %h, expected %h", pd[0], FRAME); end
    if (obs_vq[0].size() != 1) begin tests_failed++; $display("FAIL toggle pulse cycles: got %0d, expected 1", obs_vq[0].size()); end
    if (!q_match(0))           begin tests_failed++; $display("FAIL toggle model pulses: got first %0d, expected first %0d", first_of(0, 1), first_of(0, 0)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_word(FRAME >> 24, 40, 1'b0, 1'b0);
    do_reset();
    clear_obs();
    send_word(FRAME, 64, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    tests_run += 2;
    if (obs_vq[0].size() != 1 || first_of(0, 1) != 64) begin
      tests_failed++; $display("FAIL midfill pulse: got %0d pulses first at %0d, expected 1 at 64", obs_vq[0].size(), first_of(0, 1));
    end
    if (pc[0] !== 16'd1) begin tests_failed++; $display("FAIL midfill pkt_cnt: got %0d, expected 1", pc[0]); end
    send_word('1, 10, 1'b0, 1'b0);
    do_reset();
    clear_obs();
    send_word(FRAME, 64, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    tests_run += 3;
    if (obs_vq[0].size() != 1 || first_of(0, 1) != 64) begin
      tests_failed++; $display("FAIL midlock pulse: got %0d pulses first at %0d, expected 1 at 64", obs_vq[0].size(), first_of(0, 1));
    end
    if (pc[0] !== 16'd1) begin tests_failed++; $display("FAIL midlock pkt_cnt: got %0d, expected 1", pc[0]); end
    if (!q_match(1))     begin tests_failed++; $display("FAIL midlock model pulses: got %0d, expected %0d", obs_vq[1].size(), exp_vq[1].size()); end
  endtask

  task automatic test_saturate();
    do_reset();
    clear_obs();
    repeat (5) begin
      send_word(64'hAC, 8, 1'b0, 1'b0);
      send_word(FRAME, 64, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
    tests_run += 2;
    if (pc[0] !== 16'd5) begin tests_failed++; $display("FAIL sat wide pkt_cnt: got %0d, expected 5", pc[0]); end
    if (pc[2] !== 16'd3) begin tests_failed++; $display("FAIL sat narrow pkt_cnt: got %0d, expected 3", pc[2]); end
    send_word(64'hAC, 8, 1'b0, 1'b0);
    send_word(FRAME, 64, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    tests_run += 2;
    if (pc[0] !== 16'd1) begin tests_failed++; $display("FAIL clr+accept wide pkt_cnt: got %0d, expected 1", pc[0]); end
    if (pc[2] !== 16'd1) begin tests_failed++; $display("FAIL clr+accept narrow pkt_cnt: got %0d, expected 1", pc[2]); end
    for (int i = 0; i < 3; i++) begin
      tests_run += 2;
      if (!q_match(i)) begin tests_failed++; $display("FAIL sat model pulses[%0d]: got %0d, expected %0d", i, obs_vq[i].size(), exp_vq[i].size()); end
      if (pc[i] !== 16'(e_cnt[i])) begin tests_failed++; $display("FAIL sat model pkt_cnt[%0d]: got %0d, expected %0d", i, pc[i], e_cnt[i]); end
    end
  endtask

  task automatic test_random();
    logic [63:0] flip;
    do_reset();
    clear_obs();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(4, 24))
          step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);
      end else begin
        flip = '0;
        repeat ($urandom_range(0, 2)) flip[$urandom_range(0, 63)] = 1'b1;
        send_word(FRAME ^ flip, 64, 1'($urandom_range(0, 1)), 1'b0);
      end
      if (n == 30) do_reset();
    end
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests_run += 5;
      if (!q_match(i)) begin tests_failed++; $display("FAIL random pulses[%0d]: got %0d first %0d, expected %0d first %0d", i, obs_vq[i].size(), first_of(i, 1), exp_vq[i].size(), first_of(i, 0)); end
      if (pd[i] !== e_data[i]) begin tests_failed++; $display("FAIL random pkt_data[%0d]: got %h, expected %h", i, pd[i], e_data[i]); end
      if (eb[i] !== 7'(e_err[i])) begin tests_failed++; $display("FAIL random err_bits[%0d]: got %0d, expected %0d", i, eb[i], e_err[i]); end
      if (pc[i] !== 16'(e_cnt[i])) begin tests_failed++; $display("FAIL random pkt_cnt[%0d]: got %0d, expected %0d", i, pc[i], e_cnt[i]); end
      if (o_lock_sum[i] != e_lock_sum[i]) begin tests_failed++; $display("FAIL random locked cycles[%0d]: got %0d, expected %0d", i, o_lock_sum[i], e_lock_sum[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_bit_error();
    test_all_ones();
    test_en_toggle();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
